gpio_irq: RTL

Parameterised Wishbone GPIO port with per-bit direction control, two-flop input synchronisation, atomic set/clear of outputs and edge-triggered interrupts with write-1-to-clear status. It sits on the 16-bit Wishbone peripheral bus beside the other slaves and drives one level interrupt line to the interrupt controller. It replaces fixed 8-bit switch/LED ports with a single WIDTH-bit bidirectional bank.

---
 rtl/gpio_pkg.sv | 31 +++
 rtl/gpio_sync.sv | 31 +++
 rtl/gpio_irq.sv | 103 ++++++++++
 3 files changed

// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO slave: register map, set/clear selector and
// the byte-lane merge helper used by 16-bit Wishbone peripherals.
package gpio_pkg;

  typedef enum logic [2:0] {
    GPIO_DATA_IN   = 3'd0,
    GPIO_DATA_OUT  = 3'd1,
    GPIO_DIR       = 3'd2,
    GPIO_IRQ_EN    = 3'd3,
    GPIO_IRQ_RISE  = 3'd4,
    GPIO_IRQ_FALL  = 3'd5,
    GPIO_IRQ_STAT  = 3'd6,
    GPIO_OUT_SC    = 3'd7
  } gpio_reg_e;

  // Bit of the OUT_SET/OUT_CLR write data that selects clear (1) or set (0).
  localparam int GPIO_SC_BIT = 15;

  function automatic logic [15:0] byte_mask(input logic [1:0] sel);
    return {{8{sel[1]}}, {8{sel[0]}}};
  endfunction

  function automatic logic [15:0] byte_merge(input logic [15:0] old_val,
                                             input logic [15:0] new_val,
                                             input logic [1:0]  sel);
    logic [15:0] m;
    m = byte_mask(sel);
    return (old_val & ~m) | (new_val & m);
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage pin synchroniser plus a one-clock delayed copy of its output,
// giving the current (s) and previous (p) samples for edge detection.
module gpio_sync #(
  parameter int WIDTH       = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] p
);

  logic [SYNC_STAGES-1:0][WIDTH-1:0] stage;

  // NOTE: the synchroniser chain is plain flops, not a memory, so it is reset
  // like any other register; this keeps DATA_IN and the edge detector quiet
  // after reset instead of reporting a spurious edge from X.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      stage <= '0;
      p     <= '0;
    end else begin
      stage <= {stage[SYNC_STAGES-2:0], d};
      p     <= stage[SYNC_STAGES-1];
    end
  end

  assign s = stage[SYNC_STAGES-1];

endmodule

// File: rtl/gpio_irq.sv
// WIDTH-bit Wishbone GPIO bank: direction control, atomic set/clear of outputs,
// and per-bit rising/falling edge interrupts with write-1-to-clear status.
module gpio_irq
  import gpio_pkg::*;
#(
  parameter int               WIDTH       = 16,
  parameter int               SYNC_STAGES = 2,
  parameter logic [WIDTH-1:0] RST_OUT     = '0
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [2:0]       wb_adr_i,
  input  logic [15:0]      wb_dat_i,
  output logic [15:0]      wb_dat_o,
  input  logic [1:0]       wb_sel_i,
  input  logic             wb_we_i,
  input  logic             wb_stb_i,
  input  logic             wb_cyc_i,
  output logic             wb_ack_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] data_out, dir, irq_en, irq_rise, irq_fall, irq_stat;
  logic [WIDTH-1:0] sync_s, sync_p, edge_hit, stat_clr, sc_bits;
  logic [15:0]      rd_data;
  logic             req, wr;
  gpio_reg_e        reg_sel;

  gpio_sync #(.WIDTH(WIDTH), .SYNC_STAGES(SYNC_STAGES)) u_sync (
    .wb_clk_i (wb_clk_i),
    .wb_rst_i (wb_rst_i),
    .d        (gpio_i),
    .s        (sync_s),
    .p        (sync_p)
  );

  // The ack term blocks a second request in the ack cycle: one ack per 2 clocks.
  assign req     = wb_cyc_i & wb_stb_i & ~wb_ack_o;
  assign wr      = req & wb_we_i;
  assign reg_sel = gpio_reg_e'(wb_adr_i);

  assign edge_hit = (sync_s & ~sync_p & irq_rise) | (~sync_s & sync_p & irq_fall);
  assign stat_clr = (wr && reg_sel == GPIO_IRQ_STAT)
                  ? WIDTH'(wb_dat_i & byte_mask(wb_sel_i)) : '0;
  // Bit 15 is the set/clear selector, so it is never part of the mask.
  assign sc_bits  = WIDTH'({1'b0, wb_dat_i[14:0]} & byte_mask(wb_sel_i));

  // NOTE: every output of a combinational block gets a default before the
  // case, so an unlisted register index can never infer a latch.
  always_comb begin
    rd_data = '0;
    case (reg_sel)
      GPIO_DATA_IN:               rd_data = 16'(sync_s);
      GPIO_DATA_OUT, GPIO_OUT_SC: rd_data = 16'(data_out);
      GPIO_DIR:                   rd_data = 16'(dir);
      GPIO_IRQ_EN:                rd_data = 16'(irq_en);
      GPIO_IRQ_RISE:              rd_data = 16'(irq_rise);
      GPIO_IRQ_FALL:              rd_data = 16'(irq_fall);
      GPIO_IRQ_STAT:              rd_data = 16'(irq_stat);
      default:                    rd_data = '0;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
    if (!wb_rst_i) begin
      data_out <= RST_OUT;
      dir      <= '0;
      irq_en   <= '0;
      irq_rise <= '0;
      irq_fall <= '0;
      irq_stat <= '0;
      wb_ack_o <= 1'b0;
      wb_dat_o <= '0;
    end else begin
      wb_ack_o <= req;
      // A new edge in the same cycle as a W1C wins.
      irq_stat <= (irq_stat & ~stat_clr) | edge_hit;
      if (req && !wb_we_i) wb_dat_o <= rd_data;
      if (wr) begin
        case (reg_sel)
          GPIO_DATA_OUT: data_out <= WIDTH'(byte_merge(16'(data_out), wb_dat_i, wb_sel_i));
          GPIO_DIR:      dir      <= WIDTH'(byte_merge(16'(dir), wb_dat_i, wb_sel_i));
          GPIO_IRQ_EN:   irq_en   <= WIDTH'(byte_merge(16'(irq_en), wb_dat_i, wb_sel_i));
          GPIO_IRQ_RISE: irq_rise <= WIDTH'(byte_merge(16'(irq_rise), wb_dat_i, wb_sel_i));
          GPIO_IRQ_FALL: irq_fall <= WIDTH'(byte_merge(16'(irq_fall), wb_dat_i, wb_sel_i));
          GPIO_OUT_SC:   data_out <= wb_dat_i[GPIO_SC_BIT] ? (data_out & ~sc_bits)
                                                           : (data_out | sc_bits);
          default: ;
        endcase
      end
    end
  end

  assign gpio_o    = data_out;
  assign gpio_oe_o = dir;
  assign irq_o     = |(irq_stat & irq_en);

endmodule
